// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser that emits frames back-to-back.
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DELAY_FRAMES);
  localparam logic [BW-1:0] BAUD_MAX = BW'(DELAY_FRAMES - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_push, w_pop, w_empty, w_baud_end;
  logic [7:0]    w_fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  assign w_empty     = (r_count == '0);
  assign in_ready    = (r_count != CNT_FULL);
  assign w_push      = in_valid && in_ready;
  assign w_fifo_dout = r_mem[r_rd_ptr];
  assign w_baud_end  = (r_baud == BAUD_MAX);
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign fifo_count  = r_count;
  assign uart_tx     = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The line level is computed one cycle ahead so uart_tx comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^w_fifo_dout;
`endif
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
          w_tx_nxt    = 1'b0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = ^w_fifo_dout;
`endif
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table of single-byte frames, burst, wrap-around and mid-frame reset,
// with a line decoder checking every received byte against a scoreboard queue.
module tb_uart_tx_fifo;
  localparam int D     = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, uart_tx, busy;
  logic [3:0] fifo_count;

  int   n_chk = 0, n_fail = 0, cyc = 0, rx_cnt = 0;
  bit   mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int   st_q[$];

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Line decoder: samples each bit mid-cell and leaves on the last stop cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && uart_tx === 1'b0) begin
      logic [7:0] b, e;
      logic       s;
`ifdef UART_TX_PARITY_EN
      logic       p;
`endif
      st_q.push_back(cyc);
      repeat (D/2) @(negedge clk);
      chk("mon_start", int'(uart_tx), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (D) @(negedge clk);
        b[i] = uart_tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (D) @(negedge clk);
      p = uart_tx;
`endif
      repeat (D) @(negedge clk);
      s = uart_tx;
      rx_cnt++;
      chk("mon_stop", int'(s), 1);
      if (exp_q.size() == 0) chk("mon_unexpected_frame", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("mon_data", int'(b), int'(e));
`ifdef UART_TX_PARITY_EN
        chk("mon_parity", int'(p), int'(^e));
`endif
      end
      repeat (D - D/2 - 1) @(negedge clk);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct { logic [7:0] data; logic exp_par; } vec_t;

  initial begin
    vec_t vt[6];
    int   bad, rx0, n;
    logic [NB-1:0] bits;
    vt[0] = '{8'h55, 1'b0};
    vt[1] = '{8'h07, 1'b1};
    vt[2] = '{8'h03, 1'b0};
    vt[3] = '{8'hA3, 1'b0};
    vt[4] = '{8'h80, 1'b1};
    vt[5] = '{8'hFF, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",       int'(uart_tx),    1);
    chk("rst_ready",    int'(in_ready),   1);
    chk("rst_busy",     int'(busy),       0);
    chk("rst_count",    int'(fifo_count), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
    end
    chk("idle_hold", bad, 0);
    mon_en = 1'b1;

    // Single frames: exact cycle-level waveform and busy timing
    for (int v = 0; v < 6; v++) begin
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = vt[v].data[i];
`ifdef UART_TX_PARITY_EN
      bits[NB-2] = vt[v].exp_par;
`endif
      bits[NB-1] = 1'b1;
      in_data  = vt[v].data;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_q.push_back(vt[v].data);
      chk("lat_count", int'(fifo_count), 1);
      chk("lat_busy",  int'(busy),       1);
      chk("lat_tx",    int'(uart_tx),    1);
      for (int k = 0; k < NB; k++) begin
        bad = 0;
        repeat (D) begin
          @(negedge clk);
          if (uart_tx !== bits[k]) bad++;
        end
        chk($sformatf("vec%0d_bit%0d", v, k), bad, 0);
      end
      chk("busy_last_stop", int'(busy), 1);
      @(negedge clk);
      chk("busy_fall", int'(busy),    0);
      chk("tx_idle",   int'(uart_tx), 1);
    end

    // Burst of 12 with in_valid held high
    repeat (3) @(negedge clk);
    st_q.delete();
    rx0 = rx_cnt;
    for (int i = 0; i < 9; i++) push(8'(i));
    chk("full_ready", int'(in_ready),   0);
    chk("full_count", int'(fifo_count), DEPTH);
    for (int i = 9; i < 12; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 2 * FRAME) begin
        @(negedge clk);
        n++;
      end
      chk("ready_rise_count", int'(fifo_count), DEPTH - 1);
      chk("ready_rise_tx",    int'(uart_tx),    0);
      push(8'(i));
    end
    wait_idle(14 * FRAME);
    chk("burst_frames",  rx_cnt - rx0,  12);
    chk("burst_q_empty", exp_q.size(), 0);
    bad = 0;
    for (int k = 1; k < st_q.size(); k++)
      if (st_q[k] - st_q[k-1] != FRAME) bad++;
    chk("burst_contig", bad, 0);

    // Wrap-around: 4 batches of 5 distinct bytes
    rx0 = rx_cnt;
    for (int bt = 0; bt < 4; bt++) begin
      for (int j = 0; j < 5; j++) push(8'(60 + bt * 37 + j * 11));
      wait_idle(7 * FRAME);
      chk("wrap_count", int'(fifo_count), 0);
    end
    chk("wrap_frames",  rx_cnt - rx0,  20);
    chk("wrap_q_empty", exp_q.size(), 0);

    // Reset during data bit 3 of 0xA3 with three bytes queued
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    push(8'hA3);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (4 * D - 1) @(negedge clk);
    chk("pre_rst_tx",    int'(uart_tx),    0);
    chk("pre_rst_count", int'(fifo_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx",    int'(uart_tx),    1);
    chk("midrst_count", int'(fifo_count), 0);
    chk("midrst_busy",  int'(busy),       0);
    chk("midrst_ready", int'(in_ready),   1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
